// File: rtl/atari_kbd_pkg.sv
// Shared definitions for the Atari keyboard-matrix emulation blocks:
// scan address width, scan wrap endpoints, default modifier addresses and the sequencer states.
package atari_kbd_pkg;

   localparam int KEY_W = 6;
   localparam int CNT_W = 4;

   localparam logic [KEY_W-1:0] SCAN_LAST  = 6'h3F;
   localparam logic [KEY_W-1:0] SCAN_FIRST = 6'h00;

   localparam logic [KEY_W-1:0] DEF_SHIFT_ADDR = 6'h10;
   localparam logic [KEY_W-1:0] DEF_CTRL_ADDR  = 6'h00;
   localparam logic [KEY_W-1:0] DEF_BREAK_ADDR = 6'h30;

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      PRESS,
      RELEASE
   } kbdState_t;

   // A wrap is the last scan address followed directly by the first one.
   function automatic logic isScanWrap(input logic [KEY_W-1:0] prevAddr,
                                       input logic [KEY_W-1:0] curAddr);
      return (prevAddr == SCAN_LAST) && (curAddr == SCAN_FIRST);
   endfunction

endpackage

// File: rtl/scan_wrap_det.sv
// Detects the 3F->00 wrap of the POKEY keyboard scan address and emits a one-cycle pulse.
module scan_wrap_det
   import atari_kbd_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [KEY_W-1:0] keyAddr,
   output logic             wrap
);

   logic [KEY_W-1:0] prevAddr;

   // Previous address resets to the first scan address so no spurious wrap follows reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prevAddr <= SCAN_FIRST;
      end else begin
         prevAddr <= keyAddr;
      end
   end

   // The pulse is one cycle long because prevAddr becomes 00 on the following edge.
   always_comb begin
      wrap = isScanWrap(prevAddr, keyAddr);
   end

endmodule

// File: rtl/pokey_kbd_matrix_emu.sv
// Drives POKEY's active-low keyboard return lines from host key commands,
// holding each key for whole scans so it survives POKEY's debounce.
module pokey_kbd_matrix_emu
   import atari_kbd_pkg::*;
#(
   parameter int               HOLD_SCANS    = 4,
   parameter int               RELEASE_SCANS = 2,
   parameter logic [KEY_W-1:0] SHIFT_ADDR    = DEF_SHIFT_ADDR,
   parameter logic [KEY_W-1:0] CTRL_ADDR     = DEF_CTRL_ADDR,
   parameter logic [KEY_W-1:0] BREAK_ADDR    = DEF_BREAK_ADDR
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [KEY_W-1:0] keyAddr,
   input  logic             cmdValid,
   output logic             cmdReady,
   input  logic [KEY_W-1:0] cmdCode,
   input  logic             cmdShift,
   input  logic             cmdCtrl,
   input  logic             breakKey,
   output logic             nKR1,
   output logic             nKR2,
   output logic             busy
);

   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_SCANS - 1);
   localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_SCANS - 1);

   kbdState_t        state;
   kbdState_t        stateNext;
   logic [CNT_W-1:0] scanCnt;
   logic [CNT_W-1:0] scanCntNext;
   logic [KEY_W-1:0] latchCode;
   logic             latchShift;
   logic             latchCtrl;
   logic             accept;
   logic             wrap;
   logic             kr1Hit;
   logic             kr2Hit;
   logic             pressNext;

   scan_wrap_det uWrapDet (
      .clk     (clk),
      .reset   (reset),
      .keyAddr (keyAddr),
      .wrap    (wrap)
   );

   // State, scan counter and command latch; reset discards any key in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         scanCnt    <= '0;
         latchCode  <= '0;
         latchShift <= 1'b0;
         latchCtrl  <= 1'b0;
      end else begin
         state   <= stateNext;
         scanCnt <= scanCntNext;
         if (accept) begin
            latchCode  <= cmdCode;
            latchShift <= cmdShift;
            latchCtrl  <= cmdCtrl;
         end
      end
   end

   // Next-state logic: only scan wraps advance the sequence once a key is accepted,
   // so a wrap coinciding with acceptance is ignored and SYNC waits for the next one.
   always_comb begin
      stateNext   = state;
      scanCntNext = scanCnt;
      accept      = 1'b0;
      case (state)
         IDLE: begin
            if (cmdValid) begin
               accept    = 1'b1;
               stateNext = SYNC;
            end
         end
         SYNC: begin
            if (wrap) begin
               stateNext   = PRESS;
               scanCntNext = '0;
            end
         end
         PRESS: begin
            if (wrap) begin
               if (scanCnt == HOLD_LAST) begin
                  stateNext   = RELEASE;
                  scanCntNext = '0;
               end else begin
                  scanCntNext = scanCnt + 1'b1;
               end
            end
         end
         RELEASE: begin
            if (wrap) begin
               if (scanCnt == RELEASE_LAST) begin
                  stateNext   = IDLE;
                  scanCntNext = '0;
               end else begin
                  scanCntNext = scanCnt + 1'b1;
               end
            end
         end
         default: begin
            stateNext   = IDLE;
            scanCntNext = '0;
         end
      endcase
   end

   // Return decode uses the state being entered so the press window lines up with whole scans.
   always_comb begin
      pressNext = (stateNext == PRESS);
      kr1Hit    = pressNext && (keyAddr == latchCode);
      kr2Hit    = (pressNext && ((latchShift && (keyAddr == SHIFT_ADDR)) ||
                                 (latchCtrl  && (keyAddr == CTRL_ADDR)))) ||
                  (breakKey && (keyAddr == BREAK_ADDR));
   end

   // Registered returns release high asynchronously on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nKR1 <= 1'b1;
         nKR2 <= 1'b1;
      end else begin
         nKR1 <= ~kr1Hit;
         nKR2 <= ~kr2Hit;
      end
   end

   always_comb begin
      cmdReady = (state == IDLE);
      busy     = (state != IDLE);
   end

endmodule

// File: tb/tb_pokey_kbd_matrix_emu.sv
// Scoreboard testbench for pokey_kbd_matrix_emu: a behavioural model predicts the outputs
// after every clock edge, and summary counts confirm press windows, ordering and Break.
module tb_pokey_kbd_matrix_emu;

   localparam int HOLD    = 4;
   localparam int RELS    = 2;
   localparam int CLKS    = 8;
   localparam logic [5:0] A_SHIFT = 6'h10;
   localparam logic [5:0] A_CTRL  = 6'h00;
   localparam logic [5:0] A_BREAK = 6'h30;

   typedef enum logic [1:0] {M_IDLE, M_SYNC, M_PRESS, M_RELEASE} mState_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] keyAddr;
   logic       cmdValid;
   logic       cmdReady;
   logic [5:0] cmdCode;
   logic       cmdShift;
   logic       cmdCtrl;
   logic       breakKey;
   logic       nKR1;
   logic       nKR2;
   logic       busy;

   int checkCount = 0;
   int errorCount = 0;

   mState_t    mState = M_IDLE;
   int         mCnt   = 0;
   logic [5:0] mCode  = '0;
   logic       mShift = 1'b0;
   logic       mCtrl  = 1'b0;
   logic [5:0] mPrev  = '0;
   logic [3:0] expQ[$];

   int   cycle = 0;
   int   lowKr1[64];
   int   lowKr2[64];
   int   firstKr1[64];
   int   releaseLows;
   int   busyCycles;
   int   readyCycles;
   logic dropOnAccept = 1'b0;

   pokey_kbd_matrix_emu dut (
      .clk      (clk),
      .reset    (reset),
      .keyAddr  (keyAddr),
      .cmdValid (cmdValid),
      .cmdReady (cmdReady),
      .cmdCode  (cmdCode),
      .cmdShift (cmdShift),
      .cmdCtrl  (cmdCtrl),
      .breakKey (breakKey),
      .nKR1     (nKR1),
      .nKR2     (nKR2),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cycle);
      end
   endtask

   task automatic clearLogs();
      for (int i = 0; i < 64; i++) begin
         lowKr1[i]   = 0;
         lowKr2[i]   = 0;
         firstKr1[i] = -1;
      end
      releaseLows = 0;
      busyCycles  = 0;
      readyCycles = 0;
   endtask

   function automatic int sumKr1();
      int s = 0;
      for (int i = 0; i < 64; i++) s += lowKr1[i];
      return s;
   endfunction

   function automatic int sumKr2();
      int s = 0;
      for (int i = 0; i < 64; i++) s += lowKr2[i];
      return s;
   endfunction

   // One clock: predict the post-edge outputs, queue them, then compare after the edge.
   task automatic applyStimulus();
      logic       wrap;
      logic       accepted;
      mState_t    ns;
      int         nc;
      logic [5:0] sampled;
      logic [3:0] expOut;
      logic [3:0] gotOut;
      wrap     = (mPrev == 6'h3F) && (keyAddr == 6'h00);
      ns       = mState;
      nc       = mCnt;
      accepted = 1'b0;
      case (mState)
         M_IDLE: if (cmdValid) begin
            ns = M_SYNC; mCode = cmdCode; mShift = cmdShift; mCtrl = cmdCtrl; accepted = 1'b1;
         end
         M_SYNC: if (wrap) begin ns = M_PRESS; nc = 0; end
         M_PRESS: if (wrap) begin
            nc = mCnt + 1;
            if (nc == HOLD) begin ns = M_RELEASE; nc = 0; end
         end
         M_RELEASE: if (wrap) begin
            nc = mCnt + 1;
            if (nc == RELS) begin ns = M_IDLE; nc = 0; end
         end
         default: ns = M_IDLE;
      endcase
      expOut[3] = !(ns == M_PRESS && keyAddr == mCode);
      expOut[2] = !((ns == M_PRESS && ((mShift && keyAddr == A_SHIFT) || (mCtrl && keyAddr == A_CTRL))) ||
                    (breakKey && keyAddr == A_BREAK));
      expOut[1] = (ns != M_IDLE);
      expOut[0] = (ns == M_IDLE);
      expQ.push_back(expOut);
      sampled = keyAddr;
      mState  = ns;
      mCnt    = nc;
      mPrev   = keyAddr;
      @(posedge clk);
      #1;
      gotOut = {nKR1, nKR2, busy, cmdReady};
      if (expQ.size() == 0) checkOutput("queueEmpty", 1, 0);
      else checkOutput("outs", gotOut, expQ.pop_front());
      if (!nKR1) begin
         lowKr1[sampled]++;
         if (firstKr1[sampled] < 0) firstKr1[sampled] = cycle;
      end
      if (!nKR2) lowKr2[sampled]++;
      if ((!nKR1 || !nKR2) && ns == M_RELEASE) releaseLows++;
      if (busy) busyCycles++;
      if (cmdReady) readyCycles++;
      if (accepted && dropOnAccept) begin
         cmdValid     = 1'b0;
         dropOnAccept = 1'b0;
      end
      cycle++;
   endtask

   task automatic scanAddr(input logic [5:0] addr, input int clocks);
      keyAddr = addr;
      repeat (clocks) applyStimulus();
   endtask

   task automatic runScans(input int n);
      for (int s = 0; s < n; s++)
         for (int a = 0; a < 64; a++) scanAddr(6'(a), CLKS);
   endtask

   task automatic issueCmd(input logic [5:0] code, input logic sh, input logic ct);
      keyAddr  = 6'h20;
      cmdCode  = code;
      cmdShift = sh;
      cmdCtrl  = ct;
      cmdValid = 1'b1;
      applyStimulus();
      cmdValid = 1'b0;
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "Ready"}, cmdReady, 1);
      checkOutput({tag, "Busy"}, busy, 0);
   endtask

   initial begin
      reset    = 1'b1;
      keyAddr  = 6'h20;
      cmdValid = 1'b0;
      cmdCode  = '0;
      cmdShift = 1'b0;
      cmdCtrl  = 1'b0;
      breakKey = 1'b0;
      clearLogs();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("rstKr1", nKR1, 1);
      checkOutput("rstKr2", nKR2, 1);
      checkIdle("rst");

      $display("[TB] basic press 2A");
      clearLogs();
      issueCmd(6'h2A, 1'b0, 1'b0);
      runScans(8);
      checkOutput("basicKr1At2A", lowKr1[6'h2A], HOLD * CLKS);
      checkOutput("basicKr1Total", sumKr1(), HOLD * CLKS);
      checkOutput("basicKr2Total", sumKr2(), 0);
      checkIdle("basic");

      $display("[TB] modifiers with 05");
      clearLogs();
      issueCmd(6'h05, 1'b1, 1'b1);
      runScans(8);
      checkOutput("modKr1At05", lowKr1[6'h05], HOLD * CLKS);
      checkOutput("modKr2AtShift", lowKr2[6'h10], HOLD * CLKS);
      checkOutput("modKr2AtCtrl", lowKr2[6'h00], HOLD * CLKS);
      checkOutput("modKr2Total", sumKr2(), 2 * HOLD * CLKS);
      checkOutput("modReleaseLows", releaseLows, 0);
      checkIdle("mod");

      $display("[TB] back-pressure 2A then 11");
      clearLogs();
      issueCmd(6'h2A, 1'b0, 1'b0);
      cmdCode      = 6'h11;
      cmdValid     = 1'b1;
      dropOnAccept = 1'b1;
      runScans(8);
      checkOutput("bpAccepted", cmdValid, 0);
      checkOutput("bpReadyCycles", readyCycles, 1);
      runScans(7);
      checkOutput("bpKr1At2A", lowKr1[6'h2A], HOLD * CLKS);
      checkOutput("bpKr1At11", lowKr1[6'h11], HOLD * CLKS);
      checkOutput("bpOrder", firstKr1[6'h2A] < firstKr1[6'h11], 1);
      checkIdle("bp");

      $display("[TB] break while idle");
      clearLogs();
      breakKey = 1'b1;
      keyAddr  = 6'h20;
      applyStimulus();
      runScans(1);
      breakKey = 1'b0;
      checkOutput("brkKr2At30", lowKr2[6'h30], CLKS);
      checkOutput("brkKr2Total", sumKr2(), CLKS);
      checkOutput("brkBusyCycles", busyCycles, 0);

      $display("[TB] reset mid-press");
      clearLogs();
      issueCmd(6'h2A, 1'b0, 1'b0);
      runScans(2);
      for (int a = 0; a <= 6'h2A; a++) scanAddr(6'(a), CLKS);
      checkOutput("preResetKr1", nKR1, 0);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("asyncResetKr1", nKR1, 1);
      checkOutput("asyncResetKr2", nKR2, 1);
      mState = M_IDLE;
      mCnt   = 0;
      mCode  = '0;
      mShift = 1'b0;
      mCtrl  = 1'b0;
      mPrev  = '0;
      #2;
      reset = 1'b0;
      #1;
      checkIdle("postReset");
      clearLogs();
      keyAddr = 6'h20;
      applyStimulus();
      runScans(3);
      checkOutput("postResetKr1Total", sumKr1(), 0);

      $display("[TB] stalled scan");
      clearLogs();
      issueCmd(6'h17, 1'b0, 1'b0);
      scanAddr(6'h17, 10000);
      checkOutput("stallBusy", busy, 1);
      checkOutput("stallKr1Lows", sumKr1(), 0);
      runScans(8);
      checkOutput("stallKr1At17", lowKr1[6'h17], HOLD * CLKS);
      checkIdle("stall");

      $display("[TB] Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/pokey_kbd_matrix_emu.md
# pokey_kbd_matrix_emu

Keyboard-matrix emulator that drives the return side of the POKEY keyboard scan interface. It watches the 6-bit scan address that POKEY drives onto the K lines and pulls the active-low return lines (nKR1 for the main matrix, nKR2 for the modifier/Break line) at the correct addresses. This makes POKEY's debounce/compare logic register a keystroke. A host (PS/2 bridge, test sequencer or CPU) submits one key per valid/ready handshake. The block sequences press, hold for whole scans and release, so every key survives POKEY's two-scan debounce.

## Interface
- HOLD_SCANS, 4: complete scan cycles the key stays pressed; legal range 2..15.
- RELEASE_SCANS, 2: complete scan cycles with no key pressed before the next command is accepted; legal range 1..15.
- SHIFT_ADDR, 6'h10: scan address at which nKR2 reports Shift.
- CTRL_ADDR, 6'h00: scan address at which nKR2 reports Control.
- BREAK_ADDR, 6'h30: scan address at which nKR2 reports Break.
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- keyAddr  in  6  POKEY scan address K[5:0], true (non-inverted) binary.
- cmdValid  in  1  host key request valid.
- cmdReady  out  1  block can accept a request.
- cmdCode  in  6  matrix address of the key to press.
- cmdShift  in  1  hold Shift during the press.
- cmdCtrl  in  1  hold Control during the press.
- breakKey  in  1  level: Break held, independent of the command path.
- nKR1  out  1  active-low key return, main matrix.
- nKR2  out  1  active-low key return, modifiers/Break.
- busy  out  1  a key sequence is in progress.

## Operation
- States: IDLE, SYNC, PRESS, RELEASE.
- IDLE: cmdReady=1. When cmdValid&cmdReady, latch cmdCode/cmdShift/cmdCtrl and go to SYNC.
- SYNC: wait for a scan wrap, then go to PRESS with scanCnt=0.
  - Scan wrap: the registered previous keyAddr is 6'h3F and the current keyAddr is 6'h00.
- PRESS: drive the matrix as below. Each wrap increments scanCnt. At the wrap where scanCnt reaches HOLD_SCANS, go to RELEASE with scanCnt=0.
- RELEASE: no command-driven returns. Each wrap increments scanCnt. At RELEASE_SCANS, go to IDLE.
- Matrix drive (PRESS only):
  - nKR1 low when keyAddr==latched code.
  - nKR2 low when (shift latched and keyAddr==SHIFT_ADDR) or (ctrl latched and keyAddr==CTRL_ADDR).
- breakKey overrides state: nKR2 is low whenever breakKey=1 and keyAddr==BREAK_ADDR, in any state.
- busy=1 in SYNC, PRESS and RELEASE. cmdReady = (state==IDLE).
- A keyAddr that never wraps leaves the block in SYNC/PRESS indefinitely. There is no timeout; the host observes busy.
- Scan order is arbitrary. Only the 3F→00 wrap is significant, and addresses may be held for any number of clocks.

## Timing
- Reset values: state=IDLE, scanCnt=0, latched code/flags=0, nKR1=1, nKR2=1, cmdReady=1 once reset deasserts, busy=0.
- nKR1 and nKR2 are registered: they reflect the keyAddr value sampled on the previous clk edge (1-cycle latency). POKEY holds each address for many clocks, so this is safe.
- Handshake: accept occurs on the clk edge with cmdValid=cmdReady=1. cmdReady drops on the next cycle. Requests presented while busy are held off, not dropped.
- A wrap in the same cycle as acceptance is not counted. SYNC always waits for the next wrap.
- Minimum sequence length is (1 + HOLD_SCANS + RELEASE_SCANS) wraps after acceptance.
- Reset asserted mid-PRESS forces nKR1 and nKR2 high immediately (asynchronously) and discards the latched key.
- cmdCode equal to SHIFT_ADDR, CTRL_ADDR or BREAK_ADDR is legal. It only affects nKR1.

## Structure
- Shared package atari_kbd_pkg holds:
  - the state enum (IDLE, SYNC, PRESS, RELEASE);
  - SCAN_LAST=6'h3F and SCAN_FIRST=6'h00;
  - the keyAddr width constant KEY_W=6;
  - the default modifier addresses.
- Sub-module scan_wrap_det: registers keyAddr and emits a one-cycle wrap pulse. Future keyboard blocks reuse it.
- Everything else lives in a single module: FSM, 4-bit scanCnt, latch and registered return decode.

## Test plan
- Basic press: after reset, submit cmdCode=6'h2A with a scan stepping 00..3F every 8 clks. nKR1 is low only while keyAddr==2A, for exactly 4 scans after the first wrap. Then nKR1 stays high for 2 scans and cmdReady returns.
- Modifiers: cmdCode=6'h05, cmdShift=1, cmdCtrl=1. During PRESS, nKR2 is low at addresses 10 and 00, and nKR1 is low at 05. No returns during RELEASE.
- Back-pressure: hold cmdValid with a second code (6'h11) while busy. It is accepted exactly on the first cycle of IDLE. Both keys appear in order and neither is lost.
- Break: breakKey=1 while IDLE. nKR2 is low only at address 30, with busy=0 throughout.
- Reset mid-press: assert reset during PRESS while keyAddr==latched code. nKR1 goes high without a clk edge. After release, state is IDLE with cmdReady=1.
- Stalled scan: freeze keyAddr at 6'h17 after acceptance. busy stays 1 and nKR1 stays high for 10,000 clks. Resuming the scan completes the sequence normally.
